// File: rtl/booth_r4_mul.sv
// Iterative radix-4 modified-Booth multiplier: one Booth digit per cycle and a full 2*WID-bit product.
// Each transaction is signed or unsigned. It uses a vld_i/ready_o accept handshake with a one-cycle vld_o result pulse.
module booth_r4_mul #(
  parameter int WID = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld_i,
  input  logic             sgn_i,
  input  logic [WID-1:0]   op1_i,
  input  logic [WID-1:0]   op2_i,
  output logic [2*WID-1:0] prd_o,
  output logic             vld_o,
  output logic             ready_o
);

  localparam int ITER = WID / 2 + 1;
  localparam int XW   = WID + 2;      // extended multiplicand
  localparam int YW   = WID + 3;      // extended multiplier plus Booth guard zero
  localparam int PW   = WID + 4;      // partial product incl. 2X guard and sign headroom
  localparam int AW   = 2 * WID + 4;  // accumulator
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [PW-1:0] PP_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  logic [1:0]       state_q, state_d;
  logic [WID-1:0]   op1_q, op1_d;
  logic [WID-1:0]   op2_q, op2_d;
  logic             sgn_q, sgn_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WID-1:0] prd_q, prd_d;
  logic             rdy_q, rdy_d;

  logic             accept;
  logic             ext1, ext2;
  logic [PW-1:0]    x_ext, x2_ext, pp;
  logic [AW-1:0]    acc_sh, acc_next;

  assign accept = vld_i & rdy_q;
  assign ext1   = sgn_q & op1_q[WID-1];
  assign ext2   = sgn_q & op2_q[WID-1];

  // Booth digit selection from the low triplet of the shifting multiplier.
  assign x_ext  = {{2{x_q[XW-1]}}, x_q};
  assign x2_ext = x_ext << 1;

  always_comb begin
    pp = '0;
    case (y_q[2:0])
      3'b001, 3'b010: pp = x_ext;
      3'b011:         pp = x2_ext;
      3'b100:         pp = ~x2_ext + PP_ONE;
      3'b101, 3'b110: pp = ~x_ext + PP_ONE;
      default:        pp = '0;
    endcase
  end

  // Shift first, then add at the top, so digit i lands at weight 4^i after the last step.
  assign acc_sh   = {{2{acc_q[AW-1]}}, acc_q[AW-1:2]};
  assign acc_next = {acc_sh[AW-1:WID] + pp, acc_sh[WID-1:0]};

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sgn_d   = sgn_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prd_d   = prd_q;
    rdy_d   = rdy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_LOAD;
          op1_d   = op1_i;
          op2_d   = op2_i;
          sgn_d   = sgn_i;
          rdy_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end
      end
      S_LOAD: begin
        x_d     = {ext1, ext1, op1_q};
        y_d     = {ext2, ext2, op2_q, 1'b0};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        acc_d = acc_next;
        y_d   = y_q >> 2;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          prd_d   = acc_next[2*WID-1:0];
          rdy_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: synchronous reset clears every register, and all state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prd_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sgn_q   <= sgn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prd_q   <= prd_d;
      rdy_q   <= rdy_d;
    end
  end

  assign prd_o   = prd_q;
  assign vld_o   = (state_q == S_DONE);
  assign ready_o = rdy_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul (WID=64): directed literal vectors plus a cycle-level
// behavioural model of accept/latency/result compared against the outputs every cycle.
module tb_booth_r4_mul;

  localparam int WID = 64;
  localparam int LAT = 35;  // vld_o is high in the 35th cycle after the accepting edge

  logic             clk;
  logic             rstn;
  logic             vld_i;
  logic             sgn_i;
  logic [WID-1:0]   op1_i;
  logic [WID-1:0]   op2_i;
  logic [2*WID-1:0] prd_o;
  logic             vld_o;
  logic             ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  booth_r4_mul #(.WID(WID)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (vld_i),
    .sgn_i  (sgn_i),
    .op1_i  (op1_i),
    .op2_i  (op2_i),
    .prd_o  (prd_o),
    .vld_o  (vld_o),
    .ready_o(ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic signed [127:0] sa, sb;
    logic [127:0]        ua, ub;
    if (s) begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      return sa * sb;
    end
    ua = {64'd0, a};
    ub = {64'd0, b};
    return ua * ub;
  endfunction

  // Behavioural model: an accepted request yields its product LAT cycles later, with ready back
  // in that same cycle; a reset drops everything in flight.
  logic         m_ready = 1'b0;
  logic         m_vld   = 1'b0;
  logic [127:0] m_prd   = '0;
  logic [127:0] m_pend  = '0;
  int           m_cnt   = 0;

  always @(negedge clk) begin
    check("cyc_ready", {127'd0, ready_o}, {127'd0, m_ready});
    check("cyc_vld", {127'd0, vld_o}, {127'd0, m_vld});
    check("cyc_prd", prd_o, m_prd);
    if (!rstn) begin
      m_ready <= 1'b0;
      m_vld   <= 1'b0;
      m_prd   <= '0;
      m_cnt   <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
      m_vld <= 1'b0;
    end else if (m_cnt == 1) begin
      m_cnt   <= 0;
      m_vld   <= 1'b1;
      m_prd   <= m_pend;
      m_ready <= 1'b1;
    end else begin
      m_vld <= 1'b0;
      if (vld_i && m_ready) begin
        m_pend  <= ref_mul(op1_i, op2_i, sgn_i);
        m_cnt   <= LAT - 1;
        m_ready <= 1'b0;
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  // Entered and left at posedge+1. Issues one request, then checks latency, result and pulse width.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [127:0] exp, input string tag);
    int  n;
    bit  ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check({tag, "_ready_timeout"}, 128'd0, 128'd1);
      return;
    end
    vld_i = 1'b1;
    sgn_i = s;
    op1_i = a;
    op2_i = b;
    @(posedge clk); #1;
    vld_i = 1'b0;
    op1_i = {$urandom, $urandom};
    op2_i = {$urandom, $urandom};
    sgn_i = ~s;
    n = 1;
    while (!vld_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(LAT));
    check({tag, "_prd"}, prd_o, exp);
    @(posedge clk); #1;
    check({tag, "_pulse_width"}, {127'd0, vld_o}, 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] corners [5];
    int          pulses;
    corners[0] = 64'd0;
    corners[1] = 64'd1;
    corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'h7FFF_FFFF_FFFF_FFFF;

    rstn  = 1'b0;
    vld_i = 1'b0;
    sgn_i = 1'b0;
    op1_i = '0;
    op2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_prd", prd_o, 128'd0);
    check("reset_vld", {127'd0, vld_o}, 128'd0);
    check("reset_ready", {127'd0, ready_o}, 128'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {127'd0, ready_o}, 128'd1);

    do_op(64'd3, 64'd5, 1'b0, 128'd15, "u_3x5");
    do_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, "s_m3x5");
    do_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0,
          128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1, "u_m3x5");
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, "s_minxmin");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "u_maxsq");
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1,
          128'hC000_0000_0000_0000_8000_0000_0000_0000, "s_maxxmin");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, "s_m1xm1");
    do_op(64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 128'd0, "u_zero");

    // Abort an operation with a one-cycle reset at iteration 10.
    vld_i = 1'b1;
    sgn_i = 1'b0;
    op1_i = 64'd123;
    op2_i = 64'd456;
    @(posedge clk); #1;
    vld_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_prd", prd_o, 128'd0);
    check("abort_ready", {127'd0, ready_o}, 128'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_release", {127'd0, ready_o}, 128'd1);
    do_op(64'd7, 64'hFFFF_FFFF_FFFF_FFF7, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1, "s_7xm9");

    // vld_i held high with operands changing every cycle: one accept per LAT cycles.
    pulses = 0;
    vld_i  = 1'b1;
    sgn_i  = 1'b1;
    op1_i  = {$urandom, $urandom};
    op2_i  = {$urandom, $urandom};
    for (int i = 0; i < 5 * LAT; i++) begin
      @(posedge clk); #1;
      if (vld_o) pulses++;
      op1_i = {$urandom, $urandom};
      op2_i = {$urandom, $urandom};
      sgn_i = 1'($urandom);
    end
    vld_i = 1'b0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk); #1;
      if (vld_o) pulses++;
    end
    check("held_vld_pulses", 128'(pulses), 128'd5);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int s = 0; s < 2; s++)
          do_op(corners[i], corners[j], 1'(s),
                ref_mul(corners[i], corners[j], 1'(s)), "corner");

    for (int k = 0; k < 150; k++) begin
      logic [63:0] a, b;
      logic        s;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom);
      do_op(a, b, s, ref_mul(a, b, s), "random");
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
